// File: rtl/leaf_injection_arbiter.sv
// Round-robin injection scheduler for one leaf input channel: accepts a packet from
// one of N local sources and drives it out over a four-phase bundled-data req/ack handshake.
module leaf_injection_arbiter #(
  parameter int unsigned WIDTH       = 11,
  parameter int unsigned N           = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           src_valid,
  input  logic [N*WIDTH-1:0]     src_data,
  output logic [N-1:0]           src_ready,
  output logic                   out_req,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ack,
  output logic [$clog2(N)-1:0]   grant_id,
  output logic                   busy,
  output logic                   timeout
);

  localparam int unsigned GW = $clog2(N);
  localparam int unsigned CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TO_LIM  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_REQ, S_REL} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                 w_ack_s;
  logic [GW-1:0]        r_ptr;
  logic [GW-1:0]        w_win;
  logic [GW-1:0]        w_idx;
  logic                 w_found;
  logic                 w_accept;
  logic                 w_stay;
  logic [CW-1:0]        r_cnt;
  logic                 r_req;
  logic                 r_busy;
  logic                 r_timeout;
  logic [WIDTH-1:0]     r_data;
  logic [GW-1:0]        r_gid;

  // out_ack crosses from the router's domain; only the last stage is ever observed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], out_ack};
  end

  assign w_ack_s = r_sync[SYNC_STAGES-1];

  // Nearest valid source after ptr wins; scan far-to-near so the nearest overwrites last
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = int'(N); k >= 1; k--) begin
      w_idx = GW'((32'(r_ptr) + 32'(k)) % N);
      if (src_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // A held ack after reset blocks acceptance, so no handshake can complete falsely
  assign w_accept  = (r_state == S_IDLE) && w_found && !w_ack_s;
  assign src_ready = (w_accept && reset) ? (N'(1) << w_win) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_SETUP;
      S_SETUP: w_next = S_REQ;
      S_REQ:   if (w_ack_s)  w_next = S_REL;
      S_REL:   if (!w_ack_s) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Channel outputs are registered from the next state so out_req never glitches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr  <= GW'(N - 1);
      r_data <= '0;
      r_gid  <= '0;
      r_req  <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_req  <= (w_next == S_REQ);
      r_busy <= (w_next != S_IDLE);
      if (w_accept) begin
        r_data <= src_data[32'(w_win) * WIDTH +: WIDTH];
        r_gid  <= w_win;
        r_ptr  <= w_win;
      end
    end
  end

  // Stall watchdog: counts cycles held in one handshake phase; flag is sticky
  assign w_stay = ((r_state == S_REQ) || (r_state == S_REL)) && (w_next == r_state);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (!w_stay)                r_cnt <= '0;
      else if (r_cnt != CNT_MAX)  r_cnt <= r_cnt + 1'b1;
      if (w_stay && (TIMEOUT != 0) && ((r_cnt + 1'b1) >= TO_LIM)) r_timeout <= 1'b1;
    end
  end

  assign out_req  = r_req;
  assign out_data = r_data;
  assign grant_id = r_gid;
  assign busy     = r_busy;
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_leaf_injection_arbiter.sv
// Bench for leaf_injection_arbiter: a cycle-level model of the scheduling rules is checked
// against the DUT every cycle, alongside directed scenarios with hand-derived expectations.
module tb_leaf_injection_arbiter;

  localparam int unsigned W    = 11;
  localparam int unsigned N    = 4;
  localparam int unsigned SYNC = 2;
  localparam int unsigned TO   = 10;
  localparam int unsigned GW   = $clog2(N);
  localparam int PH_IDLE = 0, PH_SETUP = 1, PH_REQ = 2, PH_REL = 3;

  logic           clk       = 1'b0;
  logic           reset     = 1'b0;
  logic [N-1:0]   src_valid = '0;
  logic [N*W-1:0] src_data  = '0;
  logic [N-1:0]   src_ready;
  logic           out_req;
  logic [W-1:0]   out_data;
  logic           out_ack;
  logic [GW-1:0]  grant_id;
  logic           busy;
  logic           timeout;

  int   rt_mode  = 1;      // 0: never ack, 1: follow out_req after random delay, 2: drive rt_force
  logic rt_force = 1'b0;
  int   rt_dmin  = 0;
  int   rt_dmax  = 0;

  int n_chk   = 0;
  int n_err   = 0;
  int n_pulse = 0;
  int dut_cnt [N];

  int             m_phase, m_ptr, m_gid, m_cnt;
  logic [W-1:0]   m_data;
  logic           m_req, m_busy, m_to;
  logic [N-1:0]   m_rdy_last = '0;
  logic [SYNC-1:0] m_ackh;

  leaf_injection_arbiter #(.WIDTH(W), .N(N), .SYNC_STAGES(SYNC), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .out_req(out_req), .out_data(out_data), .out_ack(out_ack),
    .grant_id(grant_id), .busy(busy), .timeout(timeout)
  );

  always #10 clk = ~clk;

  // out_ack as the FSM is allowed to see it: SYNC rising edges late, cleared by reset
  always @(posedge clk or negedge reset) begin
    if (!reset) m_ackh <= '0;
    else        m_ackh <= {m_ackh[SYNC-2:0], out_ack};
  end

  // Router: ack edges land at a random phase inside the clock period
  initial begin
    out_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rt_mode == 2) begin
        #2;
        out_ack = rt_force;
      end else if (rt_mode == 1 && out_req != out_ack) begin
        repeat ($urandom_range(rt_dmax, rt_dmin)) @(posedge clk);
        @(posedge clk);
        #($urandom_range(19, 1));
        out_ack = ~out_ack;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_IDLE; m_ptr = N - 1; m_gid = 0; m_cnt = 0;
    m_data = '0; m_req = 1'b0; m_busy = 1'b0; m_to = 1'b0;
  endtask

  task automatic model_step(input int win, input logic acks);
    int prev;
    prev = m_phase;
    case (m_phase)
      PH_IDLE:  if (win >= 0) begin
                  m_data = src_data[win*W +: W]; m_gid = win; m_ptr = win; m_phase = PH_SETUP;
                end
      PH_SETUP: m_phase = PH_REQ;
      PH_REQ:   if (acks)  m_phase = PH_REL;
      PH_REL:   if (!acks) m_phase = PH_IDLE;
      default:  m_phase = PH_IDLE;
    endcase
    if ((prev == PH_REQ || prev == PH_REL) && m_phase == prev) begin
      m_cnt++;
      if (TO != 0 && m_cnt >= int'(TO)) m_to = 1'b1;
    end else begin
      m_cnt = 0;
    end
    m_req  = (m_phase == PH_REQ);
    m_busy = (m_phase != PH_IDLE);
  endtask

  // One clock: compare everything at the falling edge, advance the model, return after the rise
  task automatic cyc();
    logic [N-1:0]  er;
    logic [GW-1:0] j;
    logic          acks;
    int            win;
    @(negedge clk);
    er = '0; win = -1; acks = 1'b0;
    if (!reset) begin
      model_reset();
    end else begin
      acks = m_ackh[SYNC-1];
      if (m_phase == PH_IDLE && !acks)
        for (int k = 1; k <= int'(N); k++) begin
          j = GW'((m_ptr + k) % int'(N));
          if (win < 0 && src_valid[j]) win = int'(j);
        end
      if (win >= 0) er = N'(1) << win;
    end
    chk("src_ready", 32'(src_ready), 32'(er));
    chk("out_req",   32'(out_req),   32'(m_req));
    chk("out_data",  32'(out_data),  32'(m_data));
    chk("grant_id",  32'(grant_id),  32'(m_gid));
    chk("busy",      32'(busy),      32'(m_busy));
    chk("timeout",   32'(timeout),   32'(m_to));
    n_pulse += $countones(src_ready);
    for (int i = 0; i < int'(N); i++) dut_cnt[i] += int'(src_ready[i]);
    m_rdy_last = er;
    if (reset) model_step(win, acks);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int g);
    int n;
    n = 0; g = -1;
    while (g < 0 && n < 200) begin
      cyc(); n++;
      for (int i = 0; i < int'(N); i++) if (m_rdy_last[i]) g = i;
    end
    if (g < 0) begin
      n_chk++; n_err++;
      $display("FAIL wait_ready: no src_ready within %0d cycles", n);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_busy && n < 200) begin cyc(); n++; end
    if (m_busy) begin
      n_chk++; n_err++;
      $display("FAIL wait_idle: still busy after %0d cycles", n);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
  endtask

  initial begin
    int g, k, p0, n, cycles, total_gen, total_acc;
    logic bad_req, bad_rdy;
    logic [N-1:0] pend;
    int gen [N];
    int base [N];
    for (int i = 0; i < int'(N); i++) begin dut_cnt[i] = 0; gen[i] = 0; end

    // Reset values
    reset = 1'b0;
    cyc();
    chk("rst_out_req", 32'(out_req), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_timeout", 32'(timeout), 0);
    cyc();
    reset = 1'b1;

    // Single source, router acks a few cycles after req
    rt_mode = 1; rt_dmin = 2; rt_dmax = 2;
    p0 = n_pulse;
    src_valid = 4'b0001;
    src_data[0 +: W] = 11'h2A5;
    wait_ready(g);
    chk("single_grant", 32'(g), 0);
    src_valid = '0;
    chk("single_setup_data", 32'(out_data), 32'h2A5);
    chk("single_setup_req", 32'(out_req), 0);
    cyc();
    chk("single_req_rise", 32'(out_req), 1);
    wait_idle();
    chk("single_done_busy", 32'(busy), 0);
    chk("single_pulses", 32'(n_pulse - p0), 1);

    // All sources valid for 8 packets: strict rotation from source 0
    do_reset();
    rt_dmin = 0; rt_dmax = 1;
    p0 = n_pulse;
    for (int i = 0; i < int'(N); i++) src_data[i*W +: W] = W'($urandom);
    src_valid = 4'b1111;
    for (int p = 0; p < 8; p++) begin
      wait_ready(g);
      chk("rr_seq", 32'(g), 32'(p % 4));
      if (g >= 0) src_data[g*W +: W] = W'($urandom);
    end
    src_valid = '0;
    wait_idle();
    chk("rr_pulses", 32'(n_pulse - p0), 8);

    // Sources 1 and 3 after a grant to 1: 3 then 1, skipping 0 and 2
    do_reset();
    src_valid = 4'b0010;
    src_data[1*W +: W] = 11'h111;
    wait_ready(g);
    chk("skip_first", 32'(g), 1);
    src_data[3*W +: W] = 11'h333;
    src_valid = 4'b1010;
    wait_ready(g);
    chk("skip_second", 32'(g), 3);
    src_valid = 4'b0010;
    wait_ready(g);
    chk("skip_third", 32'(g), 1);
    src_valid = '0;
    wait_idle();

    // Router stalls: watchdog fires TO cycles into REQ, handshake still completes later
    do_reset();
    rt_mode = 0; rt_dmin = 0; rt_dmax = 0;
    src_valid = 4'b0001;
    src_data[0 +: W] = 11'h055;
    wait_ready(g);
    src_data[2*W +: W] = 11'h222;
    src_valid = 4'b0100;
    cyc();
    k = 0; bad_req = 1'b0; bad_rdy = 1'b0;
    while (timeout !== 1'b1 && k < 40) begin
      if (out_req !== 1'b1) bad_req = 1'b1;
      if (src_ready !== '0) bad_rdy = 1'b1;
      cyc(); k++;
    end
    chk("to_cycles", 32'(k), 32'(TO));
    chk("to_req_held", 32'(bad_req), 0);
    chk("to_no_ready", 32'(bad_rdy), 0);
    repeat (5) cyc();
    chk("to_still_req", 32'(out_req), 1);
    rt_mode = 1;
    wait_ready(g);
    chk("to_next_grant", 32'(g), 2);
    chk("to_sticky", 32'(timeout), 1);
    src_valid = '0;
    wait_idle();
    chk("to_sticky_idle", 32'(timeout), 1);

    // Reset mid-REQ with ack held; no accept until the ack release has crossed
    do_reset();
    chk("rst_clears_timeout", 32'(timeout), 0);
    rt_mode = 2; rt_force = 1'b0;
    src_valid = 4'b0001;
    src_data[0 +: W] = 11'h3C3;
    wait_ready(g);
    src_valid = '0;
    cyc();
    rt_force = 1'b1;
    cyc();
    chk("mid_req_before_rst", 32'(out_req), 1);
    reset = 1'b0;
    #1;
    chk("rst_async_req", 32'(out_req), 0);
    chk("rst_async_busy", 32'(busy), 0);
    cyc(); cyc();
    reset = 1'b1;
    repeat (3) cyc();
    src_valid = 4'b0001;
    bad_rdy = 1'b0;
    repeat (4) begin
      if (src_ready !== '0) bad_rdy = 1'b1;
      cyc();
    end
    chk("held_ack_blocks", 32'(bad_rdy), 0);
    rt_force = 1'b0;
    n = 0;
    while (src_ready === '0 && n < 10) begin cyc(); n++; end
    chk("ack_fall_to_ready", 32'(n), 2);
    wait_ready(g);
    chk("post_rst_grant", 32'(g), 0);
    src_valid = '0;
    rt_mode = 1;
    wait_idle();

    // Random traffic with asynchronous-phase acks, 500 packets
    do_reset();
    rt_mode = 1; rt_dmin = 0; rt_dmax = 3;
    p0 = n_pulse; pend = '0; cycles = 0; total_gen = 0; total_acc = 0;
    for (int i = 0; i < int'(N); i++) begin base[i] = dut_cnt[i]; gen[i] = 0; end
    while (total_acc < 500 && cycles < 30000) begin
      cyc(); cycles++;
      for (int i = 0; i < int'(N); i++)
        if (m_rdy_last[i]) begin total_acc++; pend[i] = 1'b0; end
      for (int i = 0; i < int'(N); i++)
        if (!pend[i] && total_gen < 500 && $urandom_range(3, 0) == 0) begin
          pend[i] = 1'b1;
          src_data[i*W +: W] = W'($urandom);
          gen[i]++; total_gen++;
        end
      src_valid = pend;
    end
    src_valid = '0;
    wait_idle();
    chk("rand_total_pulses", 32'(n_pulse - p0), 500);
    for (int i = 0; i < int'(N); i++)
      chk("rand_src_pulses", 32'(dut_cnt[i] - base[i]), 32'(gen[i]));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
